// File: rtl/led_serializer.sv
// led_serializer: shifts the flasher's parallel LED vector MSB-first into an
// external SIPO shift register chain (74HC595 style). It drives a divided shift
// clock and a storage-latch strobe. A frame is sent only when the vector
// differs from the last frame sent, or once after reset.
//
// Optional feature: define LED_SER_REFRESH_EN to add an idle counter. The
// counter re-sends the current vector every REFRESH_CYCLES idle cycles, which
// repairs external registers that noise has corrupted.
module led_serializer #(
    parameter int MAX_LED        = 16,
    parameter int CLK_DIV        = 4,
    parameter int REFRESH_CYCLES = 65536
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [MAX_LED-1:0] led_in,
    output logic               sr_clk,
    output logic               sr_data,
    output logic               sr_latch,
    output logic               busy,
    output logic               frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(MAX_LED);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(MAX_LED - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    // Reject parameter values the shifter cannot handle, at elaboration time.
    if (MAX_LED < 2 || CLK_DIV < 1 || REFRESH_CYCLES < 2) begin : g_bad_param
        $error("led_serializer: MAX_LED>=2, CLK_DIV>=1, REFRESH_CYCLES>=2 required");
    end

    state_t             state_q;
    logic [MAX_LED-1:0] frame_q;
    logic [MAX_LED-1:0] shadow_q;
    logic               force_q;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic               sr_clk_q;
    logic               sr_data_q;
    logic               sr_latch_q;
    logic               busy_q;
    logic               frame_done_q;

    logic               div_last;
    logic [BIT_W-1:0]   bit_nxt;
    logic               refresh_hit;
    logic               start_req;

    assign div_last = (div_cnt_q == DIV_LAST);
    assign bit_nxt  = bit_cnt_q - BIT_W'(1);

`ifdef LED_SER_REFRESH_EN
    localparam int IDLE_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [IDLE_W-1:0] idle_cnt_q;

    assign refresh_hit = (idle_cnt_q == IDLE_W'(REFRESH_CYCLES - 1));

    // Idle counter: counts IDLE cycles and restarts whenever a frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (start_req) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            end
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    // NOTE: the start condition is a continuous assign, not an always block, so
    // no path can leave it unassigned and infer a latch.
    assign start_req = (led_in != shadow_q) || force_q || refresh_hit;

    assign sr_clk     = sr_clk_q;
    assign sr_data    = sr_data_q;
    assign sr_latch   = sr_latch_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Frame sequencer: IDLE -> (SHIFT_LO -> SHIFT_HI) x MAX_LED -> LATCH -> IDLE.
    // All serial outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, including the frame and shadow vectors, gets a
        // reset value. A mid-frame reset then leaves no stale data that could
        // suppress the post-reset frame. Sequential state uses <= only.
        if (!rst_n) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            shadow_q     <= '0;
            force_q      <= 1'b1;
            div_cnt_q    <= '0;
            bit_cnt_q    <= BIT_MSB;
            sr_clk_q     <= 1'b0;
            sr_data_q    <= 1'b0;
            sr_latch_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_req) begin
                        frame_q   <= led_in;
                        force_q   <= 1'b0;
                        div_cnt_q <= '0;
                        sr_clk_q  <= 1'b0;
                        sr_data_q <= led_in[MAX_LED-1];
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_last) begin
                        div_cnt_q <= '0;
                        sr_clk_q  <= 1'b1;
                        state_q   <= SHIFT_HI;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_last) begin
                        div_cnt_q <= '0;
                        sr_clk_q  <= 1'b0;
                        if (bit_cnt_q == '0) begin
                            sr_data_q  <= 1'b0;
                            sr_latch_q <= 1'b1;
                            state_q    <= LATCH;
                        end else begin
                            bit_cnt_q <= bit_nxt;
                            sr_data_q <= frame_q[bit_nxt];
                            state_q   <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                LATCH: begin
                    if (div_last) begin
                        div_cnt_q    <= '0;
                        sr_latch_q   <= 1'b0;
                        busy_q       <= 1'b0;
                        shadow_q     <= frame_q;
                        frame_done_q <= 1'b1;
                        bit_cnt_q    <= BIT_MSB;
                        state_q      <= IDLE;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
